// File: rtl/weight_load_pkg.sv
// Shared types for the weight-load sequencer.
// State encoding and the default index width.
package weight_load_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } wl_state_t;

    localparam int WL_INDEX_WIDTH = 32;

endpackage

// File: rtl/weight_load_sequencer_index_counter_2d.sv
// Row-fastest / layer-slowest index walker.
// Holds at the final (layer, row) instead of wrapping.
module index_counter_2d #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         advance,
    input  logic [W-1:0] rows,
    input  logic [W-1:0] layers,
    output logic [W-1:0] row,
    output logic [W-1:0] layer,
    output logic         last
);

    logic [W-1:0] rows_m1;
    logic [W-1:0] layers_m1;
    logic         row_end;

    assign rows_m1   = rows - W'(1);
    assign layers_m1 = layers - W'(1);
    assign row_end   = (row == rows_m1);
    assign last      = row_end && (layer == layers_m1);

    // Index registers: clear on a new sequence, step on each accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row   <= '0;
            layer <= '0;
        end else if (clear) begin
            row   <= '0;
            layer <= '0;
        end else if (advance && !last) begin
            if (row_end) begin
                row   <= '0;
                layer <= layer + W'(1);
            end else begin
                row <= row + W'(1);
            end
        end
    end

endmodule

// File: rtl/weight_load_sequencer.sv
// Ordered (layer, row) weight-load beat generator.
// Optional pause input enabled by WEIGHT_LOAD_SEQ_HOLD_EN.
module weight_load_sequencer
    import weight_load_pkg::*;
#(
    parameter int INDEX_WIDTH = WL_INDEX_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [INDEX_WIDTH-1:0] num_layers,
    input  logic [INDEX_WIDTH-1:0] num_rows,
    input  logic                   w_ready,
`ifdef WEIGHT_LOAD_SEQ_HOLD_EN
    input  logic                   hold,
`endif
    output logic                   is_load,
    output logic [INDEX_WIDTH-1:0] w_row_index,
    output logic [INDEX_WIDTH-1:0] w_layer_index,
    output logic                   busy,
    output logic                   done
);

    wl_state_t              state;
    wl_state_t              state_nx;
    logic [INDEX_WIDTH-1:0] layers_q;
    logic [INDEX_WIDTH-1:0] rows_q;
    logic                   clear;
    logic                   accept;
    logic                   last;
    logic                   zero_size;

    assign zero_size = (num_layers == '0) || (num_rows == '0);

    // State register and count latch; counts only change on a new sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            layers_q <= '0;
            rows_q   <= '0;
        end else begin
            state <= state_nx;
            if (clear) begin
                layers_q <= num_layers;
                rows_q   <= num_rows;
            end
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_nx = state;
        is_load  = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        clear    = 1'b0;
        accept   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (zero_size) begin
                        state_nx = DONE;
                    end else begin
                        clear    = 1'b1;
                        state_nx = LOAD;
                    end
                end
            end
            LOAD: begin
                busy = 1'b1;
`ifdef WEIGHT_LOAD_SEQ_HOLD_EN
                is_load = !hold;
`else
                is_load = 1'b1;
`endif
                accept = is_load && w_ready;
                if (accept && last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    index_counter_2d #(
        .W(INDEX_WIDTH)
    ) u_idx (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .advance (accept),
        .rows    (rows_q),
        .layers  (layers_q),
        .row     (w_row_index),
        .layer   (w_layer_index),
        .last    (last)
    );

endmodule

// File: tb/tb_weight_load_sequencer.sv
// Scoreboard bench for weight_load_sequencer.
// Hold scenarios run when WEIGHT_LOAD_SEQ_HOLD_EN is defined.
module tb_weight_load_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] num_layers;
    logic [W-1:0] num_rows;
    logic         w_ready;
`ifdef WEIGHT_LOAD_SEQ_HOLD_EN
    logic         hold;
`endif
    logic         is_load;
    logic [W-1:0] w_row_index;
    logic [W-1:0] w_layer_index;
    logic         busy;
    logic         done;

    weight_load_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .num_layers    (num_layers),
        .num_rows      (num_rows),
        .w_ready       (w_ready),
`ifdef WEIGHT_LOAD_SEQ_HOLD_EN
        .hold          (hold),
`endif
        .is_load       (is_load),
        .w_row_index   (w_row_index),
        .w_layer_index (w_layer_index),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_done;
        int unsigned layer;
        int unsigned row;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    bit   expect_done_now = 1'b0;

    task automatic chk_bit(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chk_idx(string name, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every presented beat must match the queue head.
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (expect_done_now) chk_bit("done_after_last", done, 1'b1);
            expect_done_now = 1'b0;
            if (is_load) begin
                chk_bit("busy_in_load", busy, 1'b1);
                if (q.size() == 0 || q[0].is_done) begin
                    chk_bit("spurious_beat", is_load, 1'b0);
                end else begin
                    chk_idx("layer", w_layer_index, q[0].layer);
                    chk_idx("row", w_row_index, q[0].row);
                    if (w_ready) begin
                        void'(q.pop_front());
                        if (q.size() != 0 && q[0].is_done)
                            expect_done_now = 1'b1;
                    end
                end
            end
            if (done) begin
                chk_bit("done_expected",
                        q.size() != 0 && q[0].is_done, 1'b1);
                if (q.size() != 0 && q[0].is_done)
                    void'(q.pop_front());
            end
        end
    end

    // hold_mode: 0 none, 1 two-cycle hold at (0,2), 2 random.
    task automatic run_seq(int unsigned l_n, int unsigned r_n,
                           int ready_pct, bit inject, bit stall,
                           int hold_mode);
        int cyc;
        int stall_cnt = 0;
        int hold_cnt = 0;
        @(posedge clk); #1;
        start      = 1'b1;
        num_layers = l_n;
        num_rows   = r_n;
        w_ready    = ($urandom_range(99) < ready_pct);
        if (l_n != 0 && r_n != 0)
            for (int l = 0; l < int'(l_n); l++)
                for (int r = 0; r < int'(r_n); r++)
                    q.push_back('{1'b0, l, r});
        q.push_back('{1'b1, 0, 0});
        @(posedge clk); #1;
        start      = 1'b0;
        num_layers = $urandom;
        num_rows   = $urandom;
        cyc = 1;
        while (q.size() != 0) begin
            w_ready = ($urandom_range(99) < ready_pct);
            if (stall && is_load && w_layer_index == 0 &&
                w_row_index == 1 && stall_cnt < 3) begin
                w_ready = 1'b0;
                stall_cnt++;
                chk_bit("stall_is_load", is_load, 1'b1);
            end
`ifdef WEIGHT_LOAD_SEQ_HOLD_EN
            hold = 1'b0;
            if (hold_mode == 2) hold = ($urandom_range(99) < 20);
            if (hold_mode == 1 && busy && !done &&
                w_layer_index == 0 && w_row_index == 2 &&
                hold_cnt < 2) begin
                hold = 1'b1;
                hold_cnt++;
            end
            #1;
            if (hold && busy && !done)
                chk_bit("hold_gates_load", is_load, 1'b0);
            if (hold_mode == 1 && hold) begin
                chk_idx("hold_layer", w_layer_index, 0);
                chk_idx("hold_row", w_row_index, 2);
            end
`endif
            start = (inject && cyc == 2);
            if (start) begin
                num_layers = 5;
                num_rows   = 5;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            if (cyc > 400) begin
                chk_bit("seq_timeout", 1'b1, 1'b0);
                q.delete();
            end
        end
`ifdef WEIGHT_LOAD_SEQ_HOLD_EN
        hold = 1'b0;
`endif
        chk_bit("idle_busy", busy, 1'b0);
        chk_bit("idle_is_load", is_load, 1'b0);
        if (ready_pct == 100 && !stall && hold_mode == 0)
            chk_idx("seq_cycles", cyc, l_n * r_n + 2);
        if (stall) chk_idx("stall_cycles", stall_cnt, 3);
    endtask

    task automatic reset_mid_seq();
        int n = 0;
        mon_en = 1'b0;
        @(posedge clk); #1;
        start      = 1'b1;
        num_layers = 2;
        num_rows   = 3;
        w_ready    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (!(is_load && w_layer_index == 1 && w_row_index == 0)) begin
            @(posedge clk); #1;
            n++;
            if (n > 20) break;
        end
        chk_bit("reach_1_0", n <= 20, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_bit("rst_is_load", is_load, 1'b0);
        chk_bit("rst_busy", busy, 1'b0);
        chk_bit("rst_done", done, 1'b0);
        chk_idx("rst_row", w_row_index, 0);
        chk_idx("rst_layer", w_layer_index, 0);
        q.delete();
        expect_done_now = 1'b0;
        #2;
        rst_n  = 1'b1;
        mon_en = 1'b1;
    endtask

    initial begin
        int unsigned l_n;
        int unsigned r_n;
        rst_n      = 1'b0;
        start      = 1'b0;
        w_ready    = 1'b0;
        num_layers = '0;
        num_rows   = '0;
`ifdef WEIGHT_LOAD_SEQ_HOLD_EN
        hold = 1'b0;
`endif
        #12;
        chk_bit("reset_is_load", is_load, 1'b0);
        chk_bit("reset_busy", busy, 1'b0);
        chk_bit("reset_done", done, 1'b0);
        chk_idx("reset_row", w_row_index, 0);
        chk_idx("reset_layer", w_layer_index, 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        run_seq(2, 3, 100, 1'b0, 1'b0, 0);
        run_seq(2, 3, 100, 1'b0, 1'b1, 0);
        run_seq(4, 0, 100, 1'b0, 1'b0, 0);
        run_seq(0, 4, 100, 1'b0, 1'b0, 0);
        run_seq(2, 3, 100, 1'b1, 1'b0, 0);
        reset_mid_seq();
        run_seq(2, 3, 100, 1'b0, 1'b0, 0);
`ifdef WEIGHT_LOAD_SEQ_HOLD_EN
        run_seq(2, 3, 100, 1'b0, 1'b0, 1);
`endif
        run_seq(1, 1, 100, 1'b0, 1'b0, 0);

        for (int i = 0; i < 25; i++) begin
            l_n = $urandom_range(0, 3);
            r_n = $urandom_range(0, 4);
            run_seq(l_n, r_n, $urandom_range(40, 100),
                    (l_n * r_n >= 3) && $urandom_range(1),
                    1'b0, 2);
        end

        repeat (3) @(posedge clk);
        chk_idx("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
